// File: rtl/rpn_pkg.sv
// Shared opcodes, error codes and FSM encoding for the RPN command sequencer.
package rpn_pkg;

  localparam logic [2:0] OP_PUSH = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_POP  = 3'b110;
  localparam logic [2:0] OP_CLR  = 3'b111;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_UNDER = 2'b01;
  localparam logic [1:0] ERR_OVER  = 2'b10;
  localparam logic [1:0] ERR_STACK = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_POP1 = 3'd1,
    S_POP2 = 3'd2,
    S_CAP  = 3'd3,
    S_PUSH = 3'd4,
    S_CLRL = 3'd5,
    S_RESP = 3'd6
  } state_e;

  // Two-operand opcodes: pop B, pop A, push f(A, B).
  function automatic logic is_binop(input logic [2:0] op);
    return (op >= OP_ADD) && (op <= OP_XOR);
  endfunction

endpackage

// File: rtl/rpn_alu.sv
// Combinational two-operand ALU; arithmetic wraps modulo 2^WIDTH.
module rpn_alu
  import rpn_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_c
);

  always_comb begin
    result_c = '0;
    case (op_i)
      OP_ADD:  result_c = a_i + b_i;
      OP_SUB:  result_c = a_i - b_i;
      OP_AND:  result_c = a_i & b_i;
      OP_OR:   result_c = a_i | b_i;
      OP_XOR:  result_c = a_i ^ b_i;
      default: result_c = '0;
    endcase
  end

endmodule

// File: rtl/rpn_calc.sv
// RPN command sequencer: expands one command into single-cycle pulses on an
// external LIFO stack and returns one result or error per command.
module rpn_calc
  import rpn_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 8
) (
  input  logic             Clk,
  input  logic             RstN,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             res_err,
  output logic [1:0]       err_code,
  output logic             st_push,
  output logic             st_pop,
  output logic [WIDTH-1:0] st_din,
  input  logic [WIDTH-1:0] st_dout,
  input  logic             st_full,
  input  logic             st_empty,
  input  logic             st_error
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic [1:0]       code_q, code_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             cmd_ready_q, cmd_ready_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_err_q, res_err_d;
  logic [1:0]       err_code_q, err_code_d;
  logic             st_push_q, st_push_d;
  logic             st_pop_q, st_pop_d;
  logic [WIDTH-1:0] st_din_q, st_din_d;

  logic [WIDTH-1:0] alu_result;

  // A arrives on st_dout during CAP; B was captured one cycle earlier.
  rpn_alu #(.WIDTH(WIDTH)) u_alu (
    .op_i     (op_q),
    .a_i      (st_dout),
    .b_i      (b_q),
    .result_c (alu_result)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    b_d     = b_q;
    val_d   = val_q;
    code_d  = code_q;
    cnt_d   = cnt_q;

    if (st_push_q) begin
      cnt_d = cnt_q + CW'(1);
    end else if (st_pop_q) begin
      cnt_d = cnt_q - CW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          op_d   = cmd_op;
          code_d = ERR_NONE;
          val_d  = '0;
          if (cmd_op == OP_PUSH) begin
            if ((cnt_q == CW'(DEPTH)) || st_full) begin
              code_d  = ERR_OVER;
              state_d = S_RESP;
            end else begin
              val_d   = cmd_data;
              state_d = S_PUSH;
            end
          end else if (cmd_op == OP_POP) begin
            if (cnt_q == '0) begin
              code_d  = ERR_UNDER;
              state_d = S_RESP;
            end else begin
              state_d = S_POP1;
            end
          end else if (cmd_op == OP_CLR) begin
            val_d   = WIDTH'(cnt_q);
            state_d = (cnt_q == '0) ? S_RESP : S_CLRL;
          end else if (cnt_q < CW'(2)) begin
            code_d  = ERR_UNDER;
            state_d = S_RESP;
          end else begin
            state_d = S_POP1;
          end
        end
      end
      S_POP1: state_d = is_binop(op_q) ? S_POP2 : S_CAP;
      S_POP2: begin
        b_d     = st_dout;
        state_d = S_CAP;
      end
      S_CAP: begin
        if (op_q == OP_POP) begin
          val_d   = st_dout;
          state_d = S_RESP;
        end else begin
          val_d   = alu_result;
          state_d = S_PUSH;
        end
      end
      S_PUSH: state_d = S_RESP;
      S_CLRL: begin
        if (cnt_q <= CW'(1)) begin
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A stack fault ends the command early; RESP is already on its way out.
    if ((state_q != S_IDLE) && (state_q != S_RESP) && st_error) begin
      state_d = S_RESP;
      code_d  = ERR_STACK;
      if (st_empty) begin
        cnt_d = '0;
      end
    end

    st_push_d   = (state_d == S_PUSH);
    st_pop_d    = (state_d == S_POP1) || (state_d == S_POP2) || (state_d == S_CLRL);
    st_din_d    = (state_d == S_PUSH) ? val_d : '0;
    cmd_ready_d = (state_d == S_IDLE);
    res_valid_d = (state_d == S_RESP);
    res_err_d   = res_valid_d && (code_d != ERR_NONE);
    err_code_d  = res_valid_d ? code_d : ERR_NONE;
    res_data_d  = (res_valid_d && (code_d == ERR_NONE)) ? val_d : '0;
  end

  always_ff @(posedge Clk or posedge RstN) begin
    if (RstN) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      b_q         <= '0;
      val_q       <= '0;
      code_q      <= ERR_NONE;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
      err_code_q  <= ERR_NONE;
      st_push_q   <= 1'b0;
      st_pop_q    <= 1'b0;
      st_din_q    <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      b_q         <= b_d;
      val_q       <= val_d;
      code_q      <= code_d;
      cnt_q       <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
      err_code_q  <= err_code_d;
      st_push_q   <= st_push_d;
      st_pop_q    <= st_pop_d;
      st_din_q    <= st_din_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;
  assign err_code  = err_code_q;
  assign st_push   = st_push_q;
  assign st_pop    = st_pop_q;
  assign st_din    = st_din_q;

endmodule

// File: tb/tb_rpn_calc.sv
// Self-checking bench for rpn_calc: behavioural stack beside the DUT, a
// queue-based RPN model for expectations, and one per-cycle compare process.
module tb_rpn_calc;
  import rpn_pkg::*;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned DEPTH = 8;
  localparam int          MASK  = (1 << WIDTH) - 1;

  logic             Clk;
  logic             RstN;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic             res_valid;
  logic [WIDTH-1:0] res_data;
  logic             res_err;
  logic [1:0]       err_code;
  logic             st_push;
  logic             st_pop;
  logic [WIDTH-1:0] st_din;
  logic [WIDTH-1:0] st_dout;
  logic             st_full;
  logic             st_empty;
  logic             st_error;

  rpn_calc #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .Clk      (Clk),
    .RstN     (RstN),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_data (cmd_data),
    .res_valid(res_valid),
    .res_data (res_data),
    .res_err  (res_err),
    .err_code (err_code),
    .st_push  (st_push),
    .st_pop   (st_pop),
    .st_din   (st_din),
    .st_dout  (st_dout),
    .st_full  (st_full),
    .st_empty (st_empty),
    .st_error (st_error)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Behavioural LIFO: popped value shows on st_dout the cycle after the pop edge.
  logic [WIDTH-1:0] smem [16];
  logic [3:0]       sp;
  logic             serr_q;
  logic             inj_err;

  always @(posedge Clk or posedge RstN) begin
    if (RstN) begin
      sp      <= 4'd0;
      st_dout <= '0;
      serr_q  <= 1'b0;
    end else if (st_pop) begin
      if (sp == 4'd0) serr_q <= 1'b1;
      else begin
        st_dout <= smem[sp - 4'd1];
        sp      <= sp - 4'd1;
      end
    end else if (st_push) begin
      if (sp == 4'(DEPTH)) serr_q <= 1'b1;
      else begin
        smem[sp] <= st_din;
        sp       <= sp + 4'd1;
      end
    end
  end

  assign st_full  = (sp == 4'(DEPTH));
  assign st_empty = (sp == 4'd0);
  assign st_error = serr_q | inj_err;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Model state and the expectation for the command in flight.
  int mq[$];
  bit exp_armed = 1'b0;
  bit exp_done  = 1'b1;
  int exp_cyc, exp_data, exp_code, exp_push, exp_pop;
  int push_seen, pop_seen;
  int obs_data, obs_code;

  initial begin
    forever begin
      @(negedge Clk);
      if (RstN === 1'b0) begin
        chk("push_pop_exclusive", int'(st_push & st_pop), 0);
        chk("din_zero_unless_push", st_push ? 0 : int'(st_din), 0);
        if (st_push) push_seen++;
        if (st_pop) pop_seen++;
        if (exp_armed) chk("ready_low_while_busy", int'(cmd_ready), 0);
        if (res_valid) begin
          if (!exp_armed) chk("res_spurious", int'(res_valid), 0);
          else begin
            chk("res_latency", cyc, exp_cyc);
            chk("res_data", int'(res_data), exp_data);
            chk("res_err", int'(res_err), int'(exp_code != 0));
            chk("err_code", int'(err_code), exp_code);
            chk("push_pulses", push_seen, exp_push);
            chk("pop_pulses", pop_seen, exp_pop);
            obs_data  = int'(res_data);
            obs_code  = int'(err_code);
            exp_armed = 1'b0;
            exp_done  = 1'b1;
          end
        end else if (exp_armed && cyc >= exp_cyc) begin
          chk("res_missing", int'(res_valid), 1);
          obs_data  = -1;
          obs_code  = -1;
          exp_armed = 1'b0;
          exp_done  = 1'b1;
        end else if (!exp_armed) begin
          chk("pins_idle", int'(st_push | st_pop), 0);
        end
      end
    end
  end

  // Accept one command, then derive its response from the RPN rules.
  task automatic issue(input logic [2:0] op, input int d);
    int w, lat, a, b, n, e_data, e_code, e_push, e_pop;
    w = 0;
    while (cmd_ready !== 1'b1 && w < 50) begin
      @(negedge Clk);
      w++;
    end
    chk("ready_before_accept", int'(cmd_ready === 1'b1), 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = WIDTH'(d);
    @(posedge Clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 3'b000;
    cmd_data  = '0;
    e_data = 0; e_code = 0; e_push = 0; e_pop = 0; lat = 1;
    if (op == OP_PUSH) begin
      if (mq.size() == DEPTH) e_code = 2;
      else begin
        mq.push_back(d & MASK);
        e_data = d & MASK; e_push = 1; lat = 2;
      end
    end else if (op == OP_POP) begin
      if (mq.size() == 0) e_code = 1;
      else begin
        e_data = mq.pop_back(); e_pop = 1; lat = 3;
      end
    end else if (op == OP_CLR) begin
      n = mq.size();
      mq.delete();
      e_data = n & MASK; e_pop = n; lat = n + 1;
    end else if (mq.size() < 2) begin
      e_code = 1;
    end else begin
      b = mq.pop_back();
      a = mq.pop_back();
      case (op)
        OP_ADD:  e_data = (a + b) & MASK;
        OP_SUB:  e_data = (a - b) & MASK;
        OP_AND:  e_data = a & b;
        OP_OR:   e_data = a | b;
        default: e_data = a ^ b;
      endcase
      mq.push_back(e_data);
      e_pop = 2; e_push = 1; lat = 5;
    end
    exp_data  = e_data;
    exp_code  = e_code;
    exp_push  = e_push;
    exp_pop   = e_pop;
    exp_cyc   = cyc + lat - 1;
    push_seen = 0;
    pop_seen  = 0;
    exp_done  = 1'b0;
    exp_armed = 1'b1;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 64 && !exp_done; i++) begin
      @(negedge Clk);
      #1;
    end
    if (!exp_done) begin
      chk("response_timeout", int'(exp_done), 1);
      exp_armed = 1'b0;
      exp_done  = 1'b1;
    end
  endtask

  task automatic cmd(input logic [2:0] op, input int d);
    issue(op, d);
    wait_done();
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_cmd_ready"}, int'(cmd_ready), 0);
    chk({tag, "_res_valid"}, int'(res_valid), 0);
    chk({tag, "_res_data"},  int'(res_data), 0);
    chk({tag, "_res_err"},   int'(res_err), 0);
    chk({tag, "_err_code"},  int'(err_code), 0);
    chk({tag, "_st_push"},   int'(st_push), 0);
    chk({tag, "_st_pop"},    int'(st_pop), 0);
    chk({tag, "_st_din"},    int'(st_din), 0);
  endtask

  task automatic do_reset();
    RstN      = 1'b1;
    cmd_valid = 1'b0;
    exp_armed = 1'b0;
    exp_done  = 1'b1;
    mq.delete();
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    RstN = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RstN      = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 3'b000;
    cmd_data  = '0;
    inj_err   = 1'b0;
    repeat (2) @(posedge Clk);
    #2;
    chk_outs_zero("reset");
    chk("reset_cnt", int'(dut.cnt_q), 0);
    @(negedge Clk);
    RstN = 1'b0;
    @(negedge Clk);
    chk("ready_after_reset", int'(cmd_ready), 1);

    // Fill and add.
    cmd(OP_PUSH, 3);
    cmd(OP_PUSH, 5);
    cmd(OP_ADD, 0);
    chk("add_literal", obs_data, 8);
    chk("after_add_depth", int'(sp), 1);
    cmd(OP_POP, 0);
    chk("pop_after_add", obs_data, 8);

    // Subtraction wraps.
    cmd(OP_PUSH, 2);
    cmd(OP_PUSH, 5);
    cmd(OP_SUB, 0);
    chk("sub_wrap_literal", obs_data, 13);
    cmd(OP_POP, 0);
    chk("pop_after_sub", obs_data, 13);
    chk("empty_after_sub_pop", int'(st_empty), 1);

    // Underflow on empty and on a single entry.
    cmd(OP_ADD, 0);
    chk("add_underflow_code", obs_code, 1);
    cmd(OP_POP, 0);
    chk("pop_underflow_code", obs_code, 1);
    cmd(OP_PUSH, 7);
    cmd(OP_SUB, 0);
    chk("one_entry_underflow", obs_code, 1);
    cmd(OP_POP, 0);
    chk("one_entry_survives", obs_data, 7);

    // Overflow at DEPTH entries.
    for (int i = 1; i <= 8; i++) cmd(OP_PUSH, i);
    cmd(OP_PUSH, 9);
    chk("overflow_code", obs_code, 2);
    cmd(OP_POP, 0);
    chk("pop_after_overflow", obs_data, 8);
    cmd(OP_CLR, 0);
    chk("clr_seven", obs_data, 7);
    cmd(OP_CLR, 0);
    chk("clr_empty", obs_data, 0);

    // Logic ops.
    cmd(OP_PUSH, 12);
    cmd(OP_PUSH, 10);
    cmd(OP_AND, 0);
    chk("and_literal", obs_data, 8);
    cmd(OP_PUSH, 3);
    cmd(OP_OR, 0);
    chk("or_literal", obs_data, 11);
    cmd(OP_PUSH, 6);
    cmd(OP_XOR, 0);
    chk("xor_literal", obs_data, 13);
    cmd(OP_CLR, 0);

    // Clear with three entries.
    cmd(OP_PUSH, 4);
    cmd(OP_PUSH, 7);
    cmd(OP_PUSH, 9);
    cmd(OP_CLR, 0);
    chk("clr_three", obs_data, 3);
    chk("empty_after_clr", int'(st_empty), 1);

    // Stack fault during a push.
    cmd(OP_PUSH, 1);
    issue(OP_PUSH, 2);
    exp_code = 3;
    exp_data = 0;
    inj_err  = 1'b1;
    @(posedge Clk);
    #1;
    inj_err = 1'b0;
    wait_done();
    chk("stack_error_code", obs_code, 3);
    do_reset();

    // Reset during the second pop of an XOR.
    cmd(OP_PUSH, 10);
    cmd(OP_PUSH, 12);
    issue(OP_XOR, 0);
    @(posedge Clk);
    #2;
    chk("xor_in_pop2", int'(st_pop), 1);
    RstN = 1'b1;
    #1;
    chk_outs_zero("midop");
    chk("midop_cnt", int'(dut.cnt_q), 0);
    exp_armed = 1'b0;
    exp_done  = 1'b1;
    mq.delete();
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    RstN = 1'b0;
    cmd(OP_PUSH, 6);
    cmd(OP_POP, 0);
    chk("pop_after_midop_reset", obs_data, 6);
    chk("empty_at_end", int'(st_empty), 1);

    repeat (3) @(negedge Clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rpn_calc.md
# rpn_calc

Reverse-Polish command sequencer that sits directly upstream of the 4-bit `stack` block and drives its `push`/`pop`/`Data_In` pins while consuming `Data_Out`, `Full`, `Empty` and `Error`. It accepts one command at a time over a valid/ready port and expands it into the required single-cycle stack pulses. It performs the operation (push immediate, binary ALU op, pop, clear) and returns one result or error per command. It tracks stack occupancy itself so that illegal commands are rejected before any stack pin toggles.

## Interface
- `WIDTH`, 4: data width; must match the stack.
- `DEPTH`, 8: stack capacity in entries.
- `Clk` in 1: clock, rising edge.
- `RstN` in 1: asynchronous, active-high reset; the same net also resets the stack.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block idle and able to accept.
- `cmd_op` in 3: opcode; see Operation.
- `cmd_data` in WIDTH: immediate for PUSH; ignored otherwise.
- `res_valid` out 1: one-cycle pulse, one per accepted command.
- `res_data` out WIDTH: result value; 0 when `res_err`.
- `res_err` out 1: command failed.
- `err_code` out 2: 00 none, 01 underflow, 10 overflow, 11 stack error.
- `st_push`, `st_pop` out 1: to stack `push`/`pop`.
- `st_din` out WIDTH: to stack `Data_In`.
- `st_dout` in WIDTH: from stack `Data_Out`.
- `st_full`, `st_empty`, `st_error` in 1: from stack.

## Operation
- **Stack contract:** `push`/`pop` are sampled on the rising edge. A value popped at edge k appears on `st_dout` during cycle k+1.
- **Opcodes:**
  - 000 PUSH: push `cmd_data`.
  - 001 ADD: A+B.
  - 010 SUB: A−B.
  - 011 AND.
  - 100 OR.
  - 101 XOR.
  - 110 POP: return top.
  - 111 CLR: pop until empty; return count removed.
  - B is the top entry; A is second. Binary ops pop B, then A, then push the result.
- **Arithmetic:** modulo 2^WIDTH, no carry or borrow flag.
- **Occupancy:** `cnt`, 0..DEPTH, is updated on every issued push or pop.
- **Checks at accept:**
  - PUSH with `cnt==DEPTH` or `st_full`: overflow (10).
  - Binary op with `cnt<2`: underflow (01).
  - POP with `cnt==0`: underflow (01).
  - A failing command issues no stack pulse.
- **FSM states:** IDLE, POP1, POP2, CAP, PUSH, CLRL, RESP.
  - IDLE, accept: PUSH-op → PUSH; binary → POP1; POP-op → POP1; CLR → CLRL, or RESP if `cnt==0`; check failure → RESP(err).
  - POP1 (`st_pop`=1): → POP2 for binary, → CAP for POP-op.
  - POP2 (`st_pop`=1, capture B from `st_dout`) → CAP.
  - CAP: capture A (binary) or the popped value (POP-op). Then → PUSH for binary (`st_din`=result), → RESP for POP-op.
  - PUSH (`st_push`=1) → RESP.
  - CLRL: `st_pop`=1 each cycle while `cnt>1`; the last pop → RESP.
  - RESP: `res_valid`=1 → IDLE.
- **Stack error:** `st_error` sampled high in any non-IDLE state aborts to RESP with code 11. `cnt` is reset to 0 if `st_empty`, otherwise it keeps its tracked value.
- **Pin rules:** `st_push` and `st_pop` are never high together. `st_din` is 0 except in PUSH.
- **Reset:** asynchronous, any state → IDLE, `cnt`=0, all outputs 0. `cmd_ready` is 0 while `RstN` is high.

## Timing
Accept happens at edge k, i.e. `cmd_valid & cmd_ready` is sampled high.
- **PUSH:** `st_push` during cycle k+1, `res_valid` during k+2.
- **Binary op:** pops during k+1 and k+2, capture at k+3, push at k+4, `res_valid` at k+5.
- **POP:** pop at k+1, capture at k+2, `res_valid` at k+3.
- **CLR with n entries:** pops during k+1..k+n, `res_valid` at k+n+1 with `res_data`=n mod 2^WIDTH. With n=0, `res_valid` at k+1.
- **Error:** `res_valid` at k+1; `res_data`=0.
- **Ready:** `cmd_ready`=1 only in IDLE. The earliest next accept is the edge ending the RESP cycle. `res_valid` has no backpressure.
- **Outputs:** registered from state/datapath. `cmd_ready` is decoded from state.

## Structure
- Package `rpn_pkg` holds:
  - opcode localparams,
  - `err_code` values,
  - the FSM state encoding.
- One combinational sub-module `rpn_alu` (A, B, op → result). The FSM, capture registers and `cnt` stay in `rpn_calc`.
- The stack is instantiated beside this block, not inside it.

## Test plan
- **Reset, then fill:** PUSH 3, PUSH 5, ADD → `res_data`=8 at accept+5; stack holds one entry, 8.
- **SUB wrap:** PUSH 2, PUSH 5, SUB → `res_data`=13 (2−5 mod 16). A later POP returns 13 and `st_empty`=1.
- **Overflow:** 8 PUSHes (1..8), then PUSH 9 → `res_err`=1, `err_code`=10, no `st_push` pulse. A later POP returns 8.
- **Underflow:** on an empty stack, ADD and POP each → `err_code`=01 at accept+1, and `st_pop` is never asserted.
- **CLR:** PUSH 4, 7, 9, then CLR → 3 consecutive `st_pop` cycles, `res_data`=3, `st_empty`=1.
- **Reset mid-op:** assert `RstN` during POP2 of an XOR → all outputs 0 immediately, `cnt`=0. After release, PUSH 6 then POP → 6.
